// File: rtl/board_state.sv
// 11x11 Hnefatafl board store with a registered display read port
// and a move checker that walks the path before committing a move.
module board_state #(
   parameter int SIZE   = 11,
   parameter int CENTER = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] rd_row,
   input  logic [3:0] rd_col,
   output logic [1:0] rd_cell,
   input  logic       mv_valid,
   output logic       mv_ready,
   input  logic [3:0] mv_from_row,
   input  logic [3:0] mv_from_col,
   input  logic [3:0] mv_to_row,
   input  logic [3:0] mv_to_col,
   output logic       mv_done,
   output logic       mv_err,
   output logic [2:0] mv_err_code
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_WALK,
      S_COMMIT,
      S_REPORT
   } state_t;

   localparam logic [3:0] LP_MAX = 4'(SIZE - 1);
   localparam logic [3:0] LP_CTR = 4'(CENTER);

   localparam logic [1:0] C_EMPTY = 2'b00;
   localparam logic [1:0] C_KING  = 2'b11;

   localparam logic [2:0] E_NONE  = 3'b000;
   localparam logic [2:0] E_RANGE = 3'b001;
   localparam logic [2:0] E_SRC   = 3'b010;
   localparam logic [2:0] E_GEOM  = 3'b011;
   localparam logic [2:0] E_DST   = 3'b100;
   localparam logic [2:0] E_RESTR = 3'b101;
   localparam logic [2:0] E_BLOCK = 3'b110;

   function automatic int f_abs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic logic [1:0] f_start(input int r, input int c);
      int dr;
      int dc;
      dr = f_abs(r - CENTER);
      dc = f_abs(c - CENTER);
      if (r >= SIZE || c >= SIZE)
         return 2'b00;
      if (dr == 0 && dc == 0)
         return 2'b11;
      if ((dr <= 1 && dc <= 1) ||
          (dr == 0 && dc <= 2) ||
          (dc == 0 && dr <= 2))
         return 2'b10;
      if (((r == 0 || r == SIZE - 1) && dc <= 2) ||
          ((c == 0 || c == SIZE - 1) && dr <= 2) ||
          (dc == 0 && (r == 1 || r == SIZE - 2)) ||
          (dr == 0 && (c == 1 || c == SIZE - 2)))
         return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [255:0] f_start_board();
      logic [255:0] v;
      v = '0;
      for (int r = 0; r < SIZE; r++)
         for (int c = 0; c < SIZE; c++)
            v[2*(r*SIZE+c) +: 2] = f_start(r, c);
      return v;
   endfunction

   localparam logic [255:0] LP_START = f_start_board();

   function automatic logic [6:0] f_idx(
      input logic [3:0] r,
      input logic [3:0] c
   );
      return 7'({3'b000, r} * 7'd11 + {3'b000, c});
   endfunction

   // One step from a toward b; holds still on the axis not moving.
   function automatic logic [3:0] f_step(
      input logic [3:0] a,
      input logic [3:0] b
   );
      if (b > a)
         return a + 4'd1;
      if (b < a)
         return a - 4'd1;
      return a;
   endfunction

   logic [255:0] r_board;
   state_t       r_state;
   state_t       w_next;
   logic [3:0]   r_fr;
   logic [3:0]   r_fc;
   logic [3:0]   r_tr;
   logic [3:0]   r_tc;
   logic [3:0]   r_wr;
   logic [3:0]   r_wc;
   logic [2:0]   r_code;
   logic [1:0]   r_rd_cell;

   logic [6:0]   w_src_idx;
   logic [6:0]   w_dst_idx;
   logic [6:0]   w_walk_idx;
   logic [6:0]   w_rd_idx;
   logic [1:0]   w_src;
   logic [1:0]   w_dst;
   logic [1:0]   w_walk;
   logic         w_rd_ok;
   logic         w_oob;
   logic         w_same;
   logic         w_diag;
   logic         w_restr;
   logic         w_at_dst;
   logic [2:0]   w_chk_code;

   assign w_src_idx  = f_idx(r_fr, r_fc);
   assign w_dst_idx  = f_idx(r_tr, r_tc);
   assign w_walk_idx = f_idx(r_wr, r_wc);
   assign w_rd_idx   = f_idx(rd_row, rd_col);

   assign w_src  = r_board[{w_src_idx, 1'b0} +: 2];
   assign w_dst  = r_board[{w_dst_idx, 1'b0} +: 2];
   assign w_walk = r_board[{w_walk_idx, 1'b0} +: 2];

   assign w_rd_ok = (rd_row <= LP_MAX) && (rd_col <= LP_MAX);

   assign w_oob = (r_fr > LP_MAX) || (r_fc > LP_MAX) ||
                  (r_tr > LP_MAX) || (r_tc > LP_MAX);
   assign w_same = (r_fr == r_tr) && (r_fc == r_tc);
   assign w_diag = (r_fr != r_tr) && (r_fc != r_tc);
   assign w_restr =
      ((r_tr == 4'd0 || r_tr == LP_MAX) &&
       (r_tc == 4'd0 || r_tc == LP_MAX)) ||
      (r_tr == LP_CTR && r_tc == LP_CTR);
   assign w_at_dst = (r_wr == r_tr) && (r_wc == r_tc);

   always_comb begin
      w_chk_code = E_NONE;
      if (w_oob)
         w_chk_code = E_RANGE;
      else if (w_src == C_EMPTY)
         w_chk_code = E_SRC;
      else if (w_same || w_diag)
         w_chk_code = E_GEOM;
      else if (w_dst != C_EMPTY)
         w_chk_code = E_DST;
      else if (w_restr && w_src != C_KING)
         w_chk_code = E_RESTR;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:
            if (mv_valid)
               w_next = S_CHECK;
         S_CHECK:
            if (w_chk_code != E_NONE)
               w_next = S_REPORT;
            else
               w_next = S_WALK;
         S_WALK:
            if (w_at_dst)
               w_next = S_COMMIT;
            else if (w_walk != C_EMPTY)
               w_next = S_REPORT;
         S_COMMIT:
            w_next = S_REPORT;
         S_REPORT:
            w_next = S_IDLE;
         default:
            w_next = S_IDLE;
      endcase
   end

   always_comb begin
      mv_ready    = (r_state == S_IDLE);
      mv_done     = (r_state == S_REPORT);
      mv_err      = 1'b0;
      mv_err_code = E_NONE;
      if (r_state == S_REPORT) begin
         mv_err      = (r_code != E_NONE);
         mv_err_code = r_code;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fr   <= '0;
         r_fc   <= '0;
         r_tr   <= '0;
         r_tc   <= '0;
         r_wr   <= '0;
         r_wc   <= '0;
         r_code <= E_NONE;
      end else begin
         unique case (r_state)
            S_IDLE:
               if (mv_valid) begin
                  r_fr   <= mv_from_row;
                  r_fc   <= mv_from_col;
                  r_tr   <= mv_to_row;
                  r_tc   <= mv_to_col;
                  r_code <= E_NONE;
               end
            S_CHECK: begin
               r_code <= w_chk_code;
               r_wr   <= f_step(r_fr, r_tr);
               r_wc   <= f_step(r_fc, r_tc);
            end
            S_WALK:
               if (!w_at_dst) begin
                  if (w_walk != C_EMPTY)
                     r_code <= E_BLOCK;
                  else begin
                     r_wr <= f_step(r_wr, r_tr);
                     r_wc <= f_step(r_wc, r_tc);
                  end
               end
            S_COMMIT:
               r_code <= E_NONE;
            default: ;
         endcase
      end
   end

   // Only a fully walked, legal move ever writes the board.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_board <= LP_START;
      else if (r_state == S_COMMIT) begin
         r_board[{w_dst_idx, 1'b0} +: 2] <= w_src;
         r_board[{w_src_idx, 1'b0} +: 2] <= C_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_rd_cell <= C_EMPTY;
      else if (w_rd_ok)
         r_rd_cell <= r_board[{w_rd_idx, 1'b0} +: 2];
      else
         r_rd_cell <= C_EMPTY;
   end

   assign rd_cell = r_rd_cell;

endmodule

// File: tb/tb_board_state.sv
// Directed bench for board_state: start position, legal and
// rejected moves, read timing around commit, and mid-move reset.
module tb_board_state;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] rd_row;
   logic [3:0] rd_col;
   logic [1:0] rd_cell;
   logic       mv_valid;
   logic       mv_ready;
   logic [3:0] mv_from_row;
   logic [3:0] mv_from_col;
   logic [3:0] mv_to_row;
   logic [3:0] mv_to_col;
   logic       mv_done;
   logic       mv_err;
   logic [2:0] mv_err_code;

   int n_checks = 0;
   int n_fail   = 0;

   logic [1:0] last_rd;
   logic [1:0] post_rd;

   string start_map [11] = '{
      "...AAAAA...",
      ".....A.....",
      "...........",
      "A....D....A",
      "A...DDD...A",
      "AA.DDKDD.AA",
      "A...DDD...A",
      "A....D....A",
      "...........",
      ".....A.....",
      "...AAAAA..."
   };

   board_state dut (
      .clk         (clk),
      .rst         (rst),
      .rd_row      (rd_row),
      .rd_col      (rd_col),
      .rd_cell     (rd_cell),
      .mv_valid    (mv_valid),
      .mv_ready    (mv_ready),
      .mv_from_row (mv_from_row),
      .mv_from_col (mv_from_col),
      .mv_to_row   (mv_to_row),
      .mv_to_col   (mv_to_col),
      .mv_done     (mv_done),
      .mv_err      (mv_err),
      .mv_err_code (mv_err_code)
   );

   always #5 clk = ~clk;

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic rd(input int r, input int c, output logic [1:0] v);
      @(negedge clk);
      rd_row = 4'(r);
      rd_col = 4'(c);
      @(negedge clk);
      v = rd_cell;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic move(
      input string      tag,
      input int         fr,
      input int         fc,
      input int         tr,
      input int         tc,
      input int         exp_cyc,
      input logic       exp_err,
      input logic [2:0] exp_code
   );
      int n;
      int rdy_hi;
      bit seen;
      logic got_err;
      logic [2:0] got_code;
      n = 0;
      rdy_hi = 0;
      seen = 1'b0;
      got_err = 1'b0;
      got_code = 3'b000;
      @(negedge clk);
      check({tag, "_ready_idle"}, 32'(mv_ready), 1);
      mv_from_row = 4'(fr);
      mv_from_col = 4'(fc);
      mv_to_row   = 4'(tr);
      mv_to_col   = 4'(tc);
      mv_valid    = 1'b1;
      @(posedge clk);
      #1 mv_valid = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         if (mv_ready)
            rdy_hi++;
         if (mv_done) begin
            seen = 1'b1;
            got_err = mv_err;
            got_code = mv_err_code;
            last_rd = rd_cell;
         end
      end
      check({tag, "_done_seen"}, 32'(seen), 1);
      check({tag, "_cycles"}, n, exp_cyc);
      check({tag, "_err"}, 32'(got_err), 32'(exp_err));
      check({tag, "_code"}, 32'(got_code), 32'(exp_code));
      check({tag, "_ready_busy"}, rdy_hi, 0);
      @(negedge clk);
      post_rd = rd_cell;
      check({tag, "_done_pulse"}, 32'(mv_done), 0);
      check({tag, "_ready_after"}, 32'(mv_ready), 1);
   endtask

   task automatic expect_cell(input string tag, input int r, input int c,
                              input logic [1:0] exp);
      logic [1:0] v;
      rd(r, c, v);
      check(tag, 32'(v), 32'(exp));
   endtask

   initial begin
      logic [1:0] v;
      logic [1:0] e;
      int mism;
      int n_att;
      int n_def;
      int n_king;
      int n_done;
      string row_s;

      rst = 1'b0;
      mv_valid = 1'b0;
      rd_row = '0;
      rd_col = '0;
      mv_from_row = '0;
      mv_from_col = '0;
      mv_to_row = '0;
      mv_to_col = '0;

      repeat (2) @(negedge clk);
      check("rst_rd_cell", 32'(rd_cell), 0);
      check("rst_ready", 32'(mv_ready), 1);
      check("rst_done", 32'(mv_done), 0);
      check("rst_err", 32'(mv_err), 0);
      check("rst_code", 32'(mv_err_code), 0);
      rst = 1'b1;

      mism = 0;
      n_att = 0;
      n_def = 0;
      n_king = 0;
      for (int r = 0; r < 11; r++) begin
         row_s = start_map[r];
         for (int c = 0; c < 11; c++) begin
            case (row_s[c])
               "A":     e = 2'b01;
               "D":     e = 2'b10;
               "K":     e = 2'b11;
               default: e = 2'b00;
            endcase
            rd(r, c, v);
            if (v !== e)
               mism++;
            if (v == 2'b01) n_att++;
            if (v == 2'b10) n_def++;
            if (v == 2'b11) n_king++;
         end
      end
      check("start_mismatch", mism, 0);
      check("start_attackers", n_att, 24);
      check("start_defenders", n_def, 12);
      check("start_king", n_king, 1);
      expect_cell("rd_oob_row", 11, 0, 2'b00);
      expect_cell("rd_oob_col", 0, 15, 2'b00);

      move("m03_23", 0, 3, 2, 3, 5, 1'b0, 3'b000);
      expect_cell("m03_23_src", 0, 3, 2'b00);
      expect_cell("m03_23_dst", 2, 3, 2'b01);

      move("m04_03", 0, 4, 0, 3, 4, 1'b0, 3'b000);
      expect_cell("m04_03_dst", 0, 3, 2'b01);
      move("m15_10", 1, 5, 1, 0, 8, 1'b0, 3'b000);
      expect_cell("m15_10_dst", 1, 0, 2'b01);
      expect_cell("m15_10_src", 1, 5, 2'b00);

      do_reset();
      move("blocked", 0, 5, 2, 5, 3, 1'b1, 3'b110);
      expect_cell("blocked_src", 0, 5, 2'b01);
      expect_cell("blocked_mid", 1, 5, 2'b01);
      expect_cell("blocked_dst", 2, 5, 2'b00);

      do_reset();
      move("diag", 4, 4, 5, 5, 2, 1'b1, 3'b011);
      move("src_empty", 2, 2, 2, 3, 2, 1'b1, 3'b010);
      move("dst_occ", 0, 3, 0, 4, 2, 1'b1, 3'b100);
      move("row11", 11, 0, 0, 0, 2, 1'b1, 3'b001);
      move("col11", 0, 3, 0, 11, 2, 1'b1, 3'b001);
      move("same_sq", 0, 3, 0, 3, 2, 1'b1, 3'b011);
      move("corner", 0, 3, 0, 0, 2, 1'b1, 3'b101);
      expect_cell("reject_keep", 0, 3, 2'b01);
      expect_cell("reject_corner", 0, 0, 2'b00);

      do_reset();
      move("m30_20", 3, 0, 2, 0, 4, 1'b0, 3'b000);
      move("long", 2, 0, 2, 10, 13, 1'b0, 3'b000);
      expect_cell("long_dst", 2, 10, 2'b01);
      expect_cell("long_src", 2, 0, 2'b00);

      do_reset();
      @(negedge clk);
      rd_row = 4'd0;
      rd_col = 4'd3;
      move("commit_rd", 0, 3, 2, 3, 5, 1'b0, 3'b000);
      check("commit_rd_pre", 32'(last_rd), 1);
      check("commit_rd_post", 32'(post_rd), 0);

      do_reset();
      @(negedge clk);
      mv_from_row = 4'd0;
      mv_from_col = 4'd3;
      mv_to_row = 4'd2;
      mv_to_col = 4'd3;
      mv_valid = 1'b1;
      @(posedge clk);
      #1 mv_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("abort_ready", 32'(mv_ready), 1);
      check("abort_rd_cell", 32'(rd_cell), 0);
      n_done = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 1)
            rst = 1'b1;
         if (mv_done)
            n_done++;
      end
      check("abort_no_done", n_done, 0);
      expect_cell("abort_src", 0, 3, 2'b01);
      expect_cell("abort_mid", 1, 3, 2'b00);
      expect_cell("abort_dst", 2, 3, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
